// File: rtl/g_sipo_rx.sv
// rtl/g_sipo_rx.sv - framed MSB-first serial-in/parallel-out receiver with held output and ack handshake
module g_sipo_rx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLRN,
    input  logic             SDI,
    input  logic             SEN,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             OVR,
    output logic             ABRT
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] next_word;
    logic             complete;
    logic             ack_taken;

    assign next_word = {shreg[WIDTH-2:0], SDI};
    // WIDTH >= 2, so a word can only complete from SHIFT
    assign complete  = (state == SHIFT) && SEN && (cnt == CW'(WIDTH - 1));
    assign ack_taken = ACK && QV;

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            Q     <= '0;
            QV    <= 1'b0;
            OVR   <= 1'b0;
            ABRT  <= 1'b0;
        end else begin
            ABRT <= 1'b0;
            case (state)
                IDLE: begin
                    if (SEN) begin
                        shreg <= {{(WIDTH-1){1'b0}}, SDI};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!SEN) begin
                        // frame ended early: discard the partial word
                        cnt   <= '0;
                        state <= IDLE;
                        ABRT  <= 1'b1;
                    end else if (complete) begin
                        shreg <= next_word;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        shreg <= next_word;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (complete) begin
                if (!QV || ACK) begin
                    Q  <= next_word;
                    QV <= 1'b1;
                    if (ack_taken) OVR <= 1'b0;
                end else begin
                    OVR <= 1'b1;
                end
            end else if (ack_taken) begin
                QV  <= 1'b0;
                OVR <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_g_sipo_rx.sv
// tb/tb_g_sipo_rx.sv - directed self-checking bench for g_sipo_rx (WIDTH=8)
module tb_g_sipo_rx;
    logic       CLK = 1'b0;
    logic       CLRN = 1'b1;
    logic       SDI = 1'b0;
    logic       SEN = 1'b0;
    logic       ACK = 1'b0;
    logic [7:0] Q;
    logic       QV;
    logic       OVR;
    logic       ABRT;

    int errors = 0;
    int checks = 0;

    g_sipo_rx #(.WIDTH(8)) dut (
        .CLK(CLK), .CLRN(CLRN), .SDI(SDI), .SEN(SEN), .ACK(ACK),
        .Q(Q), .QV(QV), .OVR(OVR), .ABRT(ABRT)
    );

    always #5 CLK = ~CLK;

    // inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // ack_idx selects which bit position (7..0) carries ACK=1, -1 for none
    task automatic send_word(input logic [7:0] w, input int ack_idx);
        for (int i = 7; i >= 0; i--) begin
            SEN = 1'b1;
            SDI = w[i];
            ACK = (i == ack_idx);
            tick();
        end
        SEN = 1'b0;
        SDI = 1'b0;
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        SEN = 1'b1;
        SDI = 1'b1;
        tick();
        tick();
        #2 CLRN = 1'b0;
        #1;
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q actual=%h expected=00", Q); end
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL reset_qv actual=%b expected=0", QV); end
        checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL reset_ovr actual=%b expected=0", OVR); end
        checks++; if (ABRT !== 1'b0) begin errors++; $display("FAIL reset_abrt actual=%b expected=0", ABRT); end
        SEN = 1'b0;
        SDI = 1'b0;
        @(negedge CLK);
        CLRN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_first_word();
        logic [7:0] w;
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            SEN = 1'b1;
            SDI = w[i];
            tick();
        end
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL first_qv_early actual=%b expected=0", QV); end
        SDI = w[0];
        tick();
        SEN = 1'b0;
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL first_q actual=%h expected=a5", Q); end
        checks++; if (QV !== 1'b1) begin errors++; $display("FAIL first_qv actual=%b expected=1", QV); end
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (QV !== 1'b1 || Q !== 8'hA5) begin errors++; $display("FAIL hold_%0d actual=%b/%h expected=1/a5", i, QV, Q); end
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL ack_qv actual=%b expected=0", QV); end
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL ack_q_retained actual=%h expected=a5", Q); end
        tick();
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL ack_qv_stays actual=%b expected=0", QV); end
    endtask

    task automatic test_back_to_back();
        send_word(8'h3C, -1);
        checks++; if (Q !== 8'h3C || QV !== 1'b1) begin errors++; $display("FAIL b2b_first actual=%b/%h expected=1/3c", QV, Q); end
        send_word(8'hC3, 7);
        checks++; if (Q !== 8'hC3 || QV !== 1'b1) begin errors++; $display("FAIL b2b_second actual=%b/%h expected=1/c3", QV, Q); end
        checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL b2b_ovr actual=%b expected=0", OVR); end
    endtask

    task automatic test_overrun();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        send_word(8'h3C, -1);
        send_word(8'h81, -1);
        checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL ovr_q actual=%h expected=3c", Q); end
        checks++; if (OVR !== 1'b1 || QV !== 1'b1) begin errors++; $display("FAIL ovr_flag actual=%b/%b expected=1/1", OVR, QV); end
        tick();
        checks++; if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_sticky actual=%b expected=1", OVR); end
        send_word(8'h7E, 0);
        checks++; if (Q !== 8'h7E || QV !== 1'b1) begin errors++; $display("FAIL simul_q actual=%b/%h expected=1/7e", QV, Q); end
        checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL simul_ovr actual=%b expected=0", OVR); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            SEN = 1'b1;
            SDI = i[0];
            tick();
        end
        SEN = 1'b0;
        checks++; if (ABRT !== 1'b0) begin errors++; $display("FAIL abrt_early actual=%b expected=0", ABRT); end
        tick();
        checks++; if (ABRT !== 1'b1) begin errors++; $display("FAIL abrt_pulse actual=%b expected=1", ABRT); end
        checks++; if (QV !== 1'b1 || Q !== 8'h7E || OVR !== 1'b0) begin errors++; $display("FAIL abrt_hold actual=%b/%h/%b expected=1/7e/0", QV, Q, OVR); end
        tick();
        checks++; if (ABRT !== 1'b0) begin errors++; $display("FAIL abrt_width actual=%b expected=0", ABRT); end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        send_word(8'h5A, -1);
        checks++; if (Q !== 8'h5A || QV !== 1'b1) begin errors++; $display("FAIL abrt_next actual=%b/%h expected=1/5a", QV, Q); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            SEN = 1'b1;
            SDI = ~i[0];
            tick();
        end
        CLRN = 1'b0;
        SEN = 1'b0;
        #1;
        checks++; if (Q !== 8'h00 || QV !== 1'b0 || OVR !== 1'b0 || ABRT !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs actual=%h/%b/%b/%b expected=00/0/0/0", Q, QV, OVR, ABRT);
        end
        #1 CLRN = 1'b1;
        @(negedge CLK);
        checks++; if (ABRT !== 1'b0) begin errors++; $display("FAIL midrst_no_abrt actual=%b expected=0", ABRT); end
        send_word(8'hFF, -1);
        checks++; if (Q !== 8'hFF || QV !== 1'b1 || OVR !== 1'b0) begin errors++; $display("FAIL midrst_ff actual=%h/%b/%b expected=ff/1/0", Q, QV, OVR); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_first_word();
        test_handshake();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
